// File: rtl/mod_arbiter.sv
// Round-robin arbiter that shares one 32-bit MOD unit among four requesters. All outputs are registered.
// Latency: mod_start in cycle 1, ack one cycle after mod_finish (cycle 1 on B=0). Requesters hold req until their ack.
module mod_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] a_in,
    input  logic [127:0] b_in,
    output logic [3:0]   ack,
    output logic [31:0]  result,
    output logic         err,
    output logic         busy,
    output logic [31:0]  mod_a,
    output logic [31:0]  mod_b,
    output logic         mod_start,
    input  logic [31:0]  mod_result,
    input  logic         mod_finish
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    grant, grant_nxt, last_grant, last_grant_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    ack_nxt;
    logic [31:0]   result_nxt, mod_a_nxt, mod_b_nxt;
    logic          err_nxt, busy_nxt, start_nxt;

    logic          found;
    logic [1:0]    pick, idx;
    logic [31:0]   sel_a, sel_b;

    // Search starts one past the last served requester and wraps around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = last_grant + 2'(k + 1);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        sel_a = a_in[32*pick +: 32];
        sel_b = b_in[32*pick +: 32];
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        ack_nxt        = '0;
        err_nxt        = 1'b0;
        start_nxt      = 1'b0;
        result_nxt     = result;
        mod_a_nxt      = mod_a;
        mod_b_nxt      = mod_b;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = pick;
                    if (sel_b == 32'd0) begin
                        state_nxt     = DONE;
                        ack_nxt[pick] = 1'b1;
                        err_nxt       = 1'b1;
                        result_nxt    = '0;
                    end else begin
                        state_nxt = LAUNCH;
                        start_nxt = 1'b1;
                        mod_a_nxt = sel_a;
                        mod_b_nxt = sel_b;
                    end
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
                cnt_nxt   = '0;
            end
            WAIT: begin
                if (mod_finish) begin
                    state_nxt      = DONE;
                    ack_nxt[grant] = 1'b1;
                    result_nxt     = mod_result;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt      = DONE;
                    ack_nxt[grant] = 1'b1;
                    err_nxt        = 1'b1;
                    result_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                last_grant_nxt = grant;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 2'd3;
            cnt        <= '0;
            ack        <= '0;
            result     <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            mod_start  <= 1'b0;
            mod_a      <= '0;
            mod_b      <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            ack        <= ack_nxt;
            result     <= result_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
            mod_start  <= start_nxt;
            mod_a      <= mod_a_nxt;
            mod_b      <= mod_b_nxt;
        end
    end
endmodule
